// File: rtl/golomb_pkg.sv
// Shared widths, search-state encoding and ruler width helper for the
// Golomb ruler search result path.
package golomb_pkg;

    localparam int MARK_W  = 9;
    localparam int LEVEL_W = 7;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Width of a packed ruler holding marks m[0..num_positions].
    function automatic int ruler_w(input int num_positions);
        return (num_positions + 1) * MARK_W;
    endfunction

endpackage

// File: rtl/golomb_best_ruler_tracker_slot.sv
// ruler_result_slot: single-entry valid/ready holding register. A load
// always wins over a same-cycle pop; overwriting an unread entry that is
// not being popped raises a sticky overrun flag.
module ruler_result_slot #(
    parameter int W = 54
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         rd_overrun
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         overrun_q, overrun_d;

    // Next-state for the slot: pop first, then let a load refill it.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            if (valid_q && !rd_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Slot registers; reset clears data too so readout starts at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign rd_valid   = valid_q;
    assign rd_data    = data_q;
    assign rd_overrun = overrun_q;

endmodule

// File: rtl/golomb_best_ruler_tracker.sv
// golomb_best_ruler_tracker: keeps the shortest Golomb ruler reported by the
// leaf mark counter, shrinks the shared search limit on each improvement,
// offers improvements through a one-entry readout slot and flags completion.
// Optional feature macro: GOLOMB_FOUND_COUNT_EN builds the saturating
// found_count register; otherwise found_count is tied to zero.
module golomb_best_ruler_tracker
    import golomb_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int MAXVALUE     = 500,
    localparam int RW          = ruler_w(NUMPOSITIONS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               success,
    input  logic [MARK_W-1:0]  val,
    input  logic [RW-1:0]      marks_in,
    input  logic [LEVEL_W-1:0] enabled,
    output logic [MARK_W-1:0]  limit,
    output logic [RW-1:0]      best,
    output logic [MARK_W-1:0]  best_len,
    output logic [COUNT_W-1:0] found_count,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [RW-1:0]      rd_data,
    output logic               rd_overrun,
    output logic               done
);

    state_t              state_q, state_d;
    logic [MARK_W-1:0]   limit_q, limit_d;
    logic [RW-1:0]       best_q, best_d;
    logic [MARK_W-1:0]   best_len_q, best_len_d;
    logic                done_q, done_d;
    logic                accept;
    logic [RW-1:0]       candidate;
    logic                unused_last_slot;

    // The leaf supplies the last mark as val; the packed last slot is unused.
    assign candidate        = {marks_in[RW-1:MARK_W], val};
    assign unused_last_slot = ^marks_in[MARK_W-1:0];

    assign accept = (state_q == ST_SEARCH) && success &&
                    (val != '0) && (val <= limit_q);

    // Search FSM plus best-ruler and limit update on each accepted candidate.
    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        best_d     = best_q;
        best_len_d = best_len_q;
        done_d     = done_q;
        case (state_q)
            ST_IDLE: begin
                if (enabled != '0) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (enabled == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_DONE;
        endcase
        if (accept) begin
            best_d     = candidate;
            best_len_d = val;
            limit_d    = val - MARK_W'(1);
        end
    end

    // Tracker state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            limit_q    <= MARK_W'(MAXVALUE);
            best_q     <= '0;
            best_len_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            best_q     <= best_d;
            best_len_q <= best_len_d;
            done_q     <= done_d;
        end
    end

`ifdef GOLOMB_FOUND_COUNT_EN
    logic [COUNT_W-1:0] found_count_q, found_count_d;

    // Saturating count of accepted improvements.
    always_comb begin
        found_count_d = found_count_q;
        if (accept && (found_count_q != {COUNT_W{1'b1}})) begin
            found_count_d = found_count_q + COUNT_W'(1);
        end
    end

    // Improvement counter register.
    always_ff @(posedge clock) begin
        if (reset) found_count_q <= '0;
        else       found_count_q <= found_count_d;
    end

    assign found_count = found_count_q;
`else
    assign found_count = '0;
`endif

    ruler_result_slot #(.W(RW)) u_slot (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_data  (candidate),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_overrun (rd_overrun)
    );

    assign limit    = limit_q;
    assign best     = best_q;
    assign best_len = best_len_q;
    assign done     = done_q;

endmodule

// File: tb/tb_golomb_best_ruler_tracker.sv
// Directed self-checking bench for golomb_best_ruler_tracker.
module tb_golomb_best_ruler_tracker;

    logic        clock = 1'b0;
    logic        reset;
    logic        success;
    logic [8:0]  val;
    logic [53:0] marks_in;
    logic [6:0]  enabled;
    logic [8:0]  limit;
    logic [53:0] best;
    logic [8:0]  best_len;
    logic [15:0] found_count;
    logic        rd_valid;
    logic        rd_ready;
    logic [53:0] rd_data;
    logic        rd_overrun;
    logic        done;

    int checks = 0;
    int errors = 0;

    // marks 0,1,4,10,12 with the last slot left as don't-care
    localparam logic [53:0] MARKS   = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd511};
    localparam logic [53:0] RULER17 = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
    localparam logic [53:0] RULER18 = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd18};
    localparam logic [53:0] RULER15 = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd15};

    always #5 clock = ~clock;

    golomb_best_ruler_tracker #(.NUMPOSITIONS(5), .MAXVALUE(500)) dut (
        .clock       (clock),
        .reset       (reset),
        .success     (success),
        .val         (val),
        .marks_in    (marks_in),
        .enabled     (enabled),
        .limit       (limit),
        .best        (best),
        .best_len    (best_len),
        .found_count (found_count),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_overrun  (rd_overrun),
        .done        (done)
    );

    function automatic logic [15:0] exp_fc(input int n);
`ifdef GOLOMB_FOUND_COUNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_limit"},   64'(limit), 64'd500);
        check({pfx, "_best"},    64'(best), 64'd0);
        check({pfx, "_bestlen"}, 64'(best_len), 64'd0);
        check({pfx, "_fc"},      64'(found_count), 64'd0);
        check({pfx, "_rdv"},     64'(rd_valid), 64'd0);
        check({pfx, "_rddata"},  64'(rd_data), 64'd0);
        check({pfx, "_ovr"},     64'(rd_overrun), 64'd0);
        check({pfx, "_done"},    64'(done), 64'd0);
    endtask

    task automatic restart();
        reset = 1'b1; success = 1'b0; rd_ready = 1'b0; enabled = 7'd0;
        step();
        reset = 1'b0; enabled = 7'd3;
        step();
    endtask

    initial begin
        reset = 1'b1; success = 1'b0; val = 9'd0; marks_in = MARKS;
        enabled = 7'd0; rd_ready = 1'b0;
        step(); step();
        reset = 1'b0; enabled = 7'd3;
        check_reset_vals("rst");
        step();
        check("search_limit", 64'(limit), 64'd500);
        check("search_done", 64'(done), 64'd0);

        // first accept
        success = 1'b1; val = 9'd17;
        step();
        success = 1'b0;
        check("acc_bestlen", 64'(best_len), 64'd17);
        check("acc_limit", 64'(limit), 64'd16);
        check("acc_rdv", 64'(rd_valid), 64'd1);
        check("acc_fc", 64'(found_count), 64'(exp_fc(1)));
        check("acc_best", 64'(best), 64'(RULER17));
        check("acc_slot5", 64'(best[8:0]), 64'd17);
        check("acc_rddata", 64'(rd_data), 64'(RULER17));

        // same length again exceeds limit, and zero length is never accepted
        success = 1'b1; val = 9'd17;
        step();
        val = 9'd0;
        step();
        success = 1'b0;
        check("rej_limit", 64'(limit), 64'd16);
        check("rej_bestlen", 64'(best_len), 64'd17);
        check("rej_best", 64'(best), 64'(RULER17));
        check("rej_fc", 64'(found_count), 64'(exp_fc(1)));
        check("rej_ovr", 64'(rd_overrun), 64'd0);

        // two accepts without reading: overrun
        restart();
        success = 1'b1; val = 9'd20;
        step();
        val = 9'd18;
        step();
        success = 1'b0;
        check("ovr_rddata", 64'(rd_data), 64'(RULER18));
        check("ovr_flag", 64'(rd_overrun), 64'd1);
        check("ovr_limit", 64'(limit), 64'd17);
        check("ovr_fc", 64'(found_count), 64'(exp_fc(2)));

        // second accept coincides with a pop: no overrun
        restart();
        success = 1'b1; val = 9'd20;
        step();
        val = 9'd18; rd_ready = 1'b1;
        step();
        success = 1'b0;
        check("pop_rdv", 64'(rd_valid), 64'd1);
        check("pop_ovr", 64'(rd_overrun), 64'd0);
        check("pop_rddata", 64'(rd_data), 64'(RULER18));
        step();
        rd_ready = 1'b0;
        check("pop_drop", 64'(rd_valid), 64'd0);

        // search exhausted together with an accept
        enabled = 7'd0; success = 1'b1; val = 9'd15;
        step();
        check("end_limit", 64'(limit), 64'd14);
        check("end_bestlen", 64'(best_len), 64'd15);
        check("end_done", 64'(done), 64'd1);
        check("end_best", 64'(best), 64'(RULER15));
        val = 9'd10; enabled = 7'd2;
        step();
        success = 1'b0;
        check("post_limit", 64'(limit), 64'd14);
        check("post_bestlen", 64'(best_len), 64'd15);
        check("post_rdv", 64'(rd_valid), 64'd1);
        check("post_done", 64'(done), 64'd1);

        // reset mid-search with a full slot
        restart();
        success = 1'b1; val = 9'd17;
        step();
        success = 1'b0;
        check("mid_rdv", 64'(rd_valid), 64'd1);
        reset = 1'b1;
        step();
        check_reset_vals("midrst");
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
